// File: rtl/register_file_operand_fetch_pkg.sv
// Opcode encoding and operand-class decode shared by operand fetch, write-back mux and hazard logic.
package register_file_operand_fetch_pkg;

    typedef enum logic [3:0] {
        OPCODE_ADD  = 4'd0,
        OPCODE_SUB  = 4'd1,
        OPCODE_AND  = 4'd2,
        OPCODE_OR   = 4'd3,
        OPCODE_XOR  = 4'd4,
        OPCODE_NOT  = 4'd5,
        OPCODE_LSL  = 4'd6,
        OPCODE_LSR  = 4'd7,
        OPCODE_ADDI = 4'd8,
        OPCODE_SUBI = 4'd9,
        OPCODE_MOV1 = 4'd10,
        OPCODE_MOV2 = 4'd11,
        OPCODE_LDUR = 4'd12,
        OPCODE_STUR = 4'd13,
        OPCODE_CBZ  = 4'd14
    } opcode_t;

    typedef enum logic [2:0] {
        OPC_NONE     = 3'd0,
        OPC_TWO_REG  = 3'd1,
        OPC_REG_IMM  = 3'd2,
        OPC_ONE_REG  = 3'd3,
        OPC_IMM_ONLY = 3'd4
    } operand_class_t;

    function automatic operand_class_t operand_class(input opcode_t op);
        operand_class_t cls;
        case (op)
            OPCODE_ADD, OPCODE_SUB, OPCODE_AND, OPCODE_OR, OPCODE_XOR: cls = OPC_TWO_REG;
            OPCODE_ADDI, OPCODE_SUBI, OPCODE_LSL, OPCODE_LSR:          cls = OPC_REG_IMM;
            OPCODE_NOT, OPCODE_MOV1, OPCODE_LDUR:                      cls = OPC_ONE_REG;
            OPCODE_MOV2:                                               cls = OPC_IMM_ONLY;
            default:                                                   cls = OPC_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/register_file_operand_fetch.sv
// Operand fetch: decodes an instruction, reads up to two operands through the single
// synchronous-read register-file port and hands {instr, op_a, op_b} to execute.
module register_file_operand_fetch
    import register_file_operand_fetch_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        instr,
    output logic              rf_re,
    output logic [REG_AW-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_instr,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE_A = 3'd1,
        ST_ISSUE_B = 3'd2,
        ST_CAP_B   = 3'd3,
        ST_CAP_A   = 3'd4,
        ST_VALID   = 3'd5
    } state_t;

    state_t         state_r;
    state_t         next_state_s;
    operand_class_t in_cls_s;
    operand_class_t cls_s;
    logic [DATA_W-1:0] in_imm_s;
    logic [DATA_W-1:0] imm_s;

    assign in_cls_s  = operand_class(opcode_t'(instr[7:4]));
    assign cls_s     = operand_class(opcode_t'(out_instr[7:4]));
    assign in_imm_s  = DATA_W'(instr[1:0]);
    assign imm_s     = DATA_W'(out_instr[1:0]);
    assign in_ready  = (state_r == ST_IDLE);
    assign out_valid = (state_r == ST_VALID);

    // Next-state and register-file read request decode
    always_comb begin
        next_state_s = state_r;
        rf_re        = 1'b0;
        rf_raddr     = {REG_AW{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    case (in_cls_s)
                        OPC_TWO_REG, OPC_REG_IMM, OPC_ONE_REG: next_state_s = ST_ISSUE_A;
                        default:                               next_state_s = ST_VALID;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ISSUE_A: begin
                rf_re = 1'b1;
                if (cls_s == OPC_ONE_REG) begin
                    rf_raddr = REG_AW'(out_instr[1:0]);
                end else begin
                    rf_raddr = REG_AW'(out_instr[3:2]);
                end
                if (cls_s == OPC_TWO_REG) begin
                    next_state_s = ST_ISSUE_B;
                end else begin
                    next_state_s = ST_CAP_A;
                end
            end
            ST_ISSUE_B: begin
                rf_re        = 1'b1;
                rf_raddr     = REG_AW'(out_instr[1:0]);
                next_state_s = ST_CAP_B;
            end
            ST_CAP_B: next_state_s = ST_VALID;
            ST_CAP_A: next_state_s = ST_VALID;
            ST_VALID: begin
                if (out_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_VALID;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register and operand capture; flush aborts without touching latched operands
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            out_instr <= 8'd0;
            op_a      <= {DATA_W{1'b0}};
            op_b      <= {DATA_W{1'b0}};
        end else if (flush) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        out_instr <= instr;
                        op_a      <= {DATA_W{1'b0}};
                        op_b      <= (in_cls_s == OPC_IMM_ONLY) ? in_imm_s : {DATA_W{1'b0}};
                    end
                end
                // rf_rdata here is the ISSUE_A read; the ISSUE_B read lands in CAP_B
                ST_ISSUE_B: op_a <= rf_rdata;
                ST_CAP_A: begin
                    op_a <= rf_rdata;
                    if (cls_s == OPC_REG_IMM) begin
                        op_b <= imm_s;
                    end
                end
                ST_CAP_B: op_b <= rf_rdata;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_register_file_operand_fetch.sv
// Self-checking bench: directed scenarios plus a randomized stream against a class-table reference model.
module tb_register_file_operand_fetch;
    import register_file_operand_fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, out_ready;
    logic       in_ready, rf_re, out_valid;
    logic [7:0] instr, out_instr, op_a, op_b, rf_rdata;
    logic [1:0] rf_raddr;
    logic [7:0] regs [4];
    int checks = 0;
    int failures = 0;

    register_file_operand_fetch #(.DATA_W(8), .REG_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .rf_re(rf_re), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .op_a(op_a), .op_b(op_b)
    );

    always #5 clk = ~clk;

    // synchronous-read register file model
    always @(posedge clk) if (rf_re) rf_rdata <= regs[rf_raddr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one instruction from IDLE to retirement; records latency, reads and captured outputs.
    task automatic issue(input logic [7:0] ins, input int hold, input bit noisy,
                         output int lat, output logic [7:0] a_o, output logic [7:0] b_o,
                         output logic [7:0] i_o, output int nre,
                         output logic [1:0] ad0, output logic [1:0] ad1);
        ad0 = 2'd0; ad1 = 2'd0; nre = 0;
        in_valid = 1'b1; instr = ins; out_ready = (hold == 0);
        step();
        lat = 1;
        while (!out_valid && lat < 20) begin
            if (rf_re) begin
                if (nre == 0) ad0 = rf_raddr;
                else if (nre == 1) ad1 = rf_raddr;
                nre++;
            end
            in_valid = noisy ? 1'($urandom) : 1'b0;
            instr = 8'($urandom);
            if (noisy) out_ready = 1'($urandom);
            step();
            lat++;
        end
        a_o = op_a; b_o = op_b; i_o = out_instr;
        if (out_valid) begin
            out_ready = 1'b0;
            repeat (hold) step();
            out_ready = 1'b1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = 8'd0;
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
        step(); step();
        checks++;
        if (out_valid !== 1'b0 || rf_re !== 1'b0 || rf_raddr !== 2'd0 || out_instr !== 8'd0 ||
            op_a !== 8'd0 || op_b !== 8'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: ov=%b re=%b ra=%0d oi=%h a=%h b=%h ir=%b expected 0 0 0 00 00 00 1",
                     out_valid, rf_re, rf_raddr, out_instr, op_a, op_b, in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add();
        int lat, nre; logic [7:0] a, b, io; logic [1:0] d0, d1;
        issue({OPCODE_ADD, 2'd1, 2'd2}, 0, 1'b0, lat, a, b, io, nre, d0, d1);
        checks++;
        if (lat !== 4 || a !== 8'h22 || b !== 8'h33) begin
            failures++;
            $display("FAIL add: lat=%0d a=%h b=%h expected 4 22 33", lat, a, b);
        end
        checks++;
        if (nre !== 2 || d0 !== 2'd1 || d1 !== 2'd2) begin
            failures++;
            $display("FAIL add_reads: n=%0d %0d,%0d expected 2 1,2", nre, d0, d1);
        end
    endtask

    task automatic test_addi_mov2();
        int lat, nre; logic [7:0] a, b, io; logic [1:0] d0, d1;
        issue({OPCODE_ADDI, 2'd3, 2'd2}, 0, 1'b0, lat, a, b, io, nre, d0, d1);
        checks++;
        if (lat !== 3 || a !== 8'h44 || b !== 8'h02 || nre !== 1 || d0 !== 2'd3) begin
            failures++;
            $display("FAIL addi: lat=%0d a=%h b=%h n=%0d ad=%0d expected 3 44 02 1 3", lat, a, b, nre, d0);
        end
        issue({OPCODE_MOV2, 2'd0, 2'd3}, 0, 1'b0, lat, a, b, io, nre, d0, d1);
        checks++;
        if (lat !== 1 || a !== 8'h00 || b !== 8'h03 || nre !== 0) begin
            failures++;
            $display("FAIL mov2: lat=%0d a=%h b=%h n=%0d expected 1 00 03 0", lat, a, b, nre);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        bit bad = 1'b0;
        in_valid = 1'b1; instr = {OPCODE_NOT, 2'd0, 2'd2}; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        while (!out_valid && n < 20) begin step(); n++; end
        repeat (5) begin
            if (out_valid !== 1'b1 || op_a !== 8'h33 || op_b !== 8'h00 || in_ready !== 1'b0) bad = 1'b1;
            step();
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL backpressure_hold: ov=%b a=%h ir=%b expected 1 33 0 held", out_valid, op_a, in_ready);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_release: ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_flush();
        int lat, nre; logic [7:0] a, b, io; logic [1:0] d0, d1;
        bit rose = 1'b0;
        in_valid = 1'b1; instr = {OPCODE_SUB, 2'd0, 2'd1}; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (rf_re !== 1'b1 || rf_raddr !== 2'd1) begin
            failures++;
            $display("FAIL flush_issue_b: re=%b ra=%0d expected 1 1", rf_re, rf_raddr);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (rf_re !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_next: re=%b ir=%b ov=%b expected 0 1 0", rf_re, in_ready, out_valid);
        end
        repeat (4) begin if (out_valid) rose = 1'b1; step(); end
        checks++;
        if (rose) begin
            failures++;
            $display("FAIL flush_no_valid: out_valid rose, expected 0");
        end
        in_valid = 1'b1; flush = 1'b1; instr = {OPCODE_MOV2, 2'd0, 2'd1};
        step();
        in_valid = 1'b0; flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop: ir=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        out_ready = 1'b0;
        issue({OPCODE_XOR, 2'd3, 2'd3}, 0, 1'b0, lat, a, b, io, nre, d0, d1);
        checks++;
        if (lat !== 4 || a !== 8'h44 || b !== 8'h44 || nre !== 2 || d0 !== 2'd3 || d1 !== 2'd3) begin
            failures++;
            $display("FAIL xor_after_flush: lat=%0d a=%h b=%h n=%0d expected 4 44 44 2", lat, a, b, nre);
        end
    endtask

    task automatic test_reset_mid();
        int lat, nre; logic [7:0] a, b, io; logic [1:0] d0, d1;
        in_valid = 1'b1; instr = {OPCODE_ADD, 2'd0, 2'd3};
        step();
        in_valid = 1'b0;
        step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || rf_re !== 1'b0 || rf_raddr !== 2'd0 || out_instr !== 8'd0 ||
            op_a !== 8'd0 || op_b !== 8'd0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid: ov=%b re=%b oi=%h a=%h b=%h ir=%b expected 0 0 00 00 00 1",
                     out_valid, rf_re, out_instr, op_a, op_b, in_ready);
        end
        issue({4'hF, 2'd2, 2'd3}, 0, 1'b0, lat, a, b, io, nre, d0, d1);
        checks++;
        if (lat !== 1 || a !== 8'h00 || b !== 8'h00 || nre !== 0) begin
            failures++;
            $display("FAIL undefined_op: lat=%0d a=%h b=%h n=%0d expected 1 00 00 0", lat, a, b, nre);
        end
    endtask

    task automatic test_random();
        int lat, nre, cls, elat, enre;
        logic [7:0] a, b, io, ins, ea, eb;
        logic [1:0] d0, d1, rd, rs;
        for (int k = 0; k < 300; k++) begin
            for (int r = 0; r < 4; r++) regs[r] = 8'($urandom);
            ins = 8'($urandom);
            rd = ins[3:2]; rs = ins[1:0];
            case (ins[7:4])
                4'd0, 4'd1, 4'd2, 4'd3, 4'd4: cls = 1;
                4'd6, 4'd7, 4'd8, 4'd9:       cls = 2;
                4'd5, 4'd10, 4'd12:           cls = 3;
                4'd11:                        cls = 4;
                default:                      cls = 0;
            endcase
            case (cls)
                1:       begin ea = regs[rd]; eb = regs[rs];    elat = 4; enre = 2; end
                2:       begin ea = regs[rd]; eb = {6'd0, rs};  elat = 3; enre = 1; end
                3:       begin ea = regs[rs]; eb = 8'd0;        elat = 3; enre = 1; end
                4:       begin ea = 8'd0;     eb = {6'd0, rs};  elat = 1; enre = 0; end
                default: begin ea = 8'd0;     eb = 8'd0;        elat = 1; enre = 0; end
            endcase
            issue(ins, int'($urandom_range(0, 3)), 1'b1, lat, a, b, io, nre, d0, d1);
            checks++;
            if (lat !== elat || a !== ea || b !== eb || io !== ins) begin
                failures++;
                $display("FAIL random_ops[%0d] ins=%h: lat=%0d a=%h b=%h oi=%h expected %0d %h %h %h",
                         k, ins, lat, a, b, io, elat, ea, eb, ins);
            end
            checks++;
            if (nre !== enre || (enre >= 1 && d0 !== ((cls == 3) ? rs : rd)) || (enre == 2 && d1 !== rs)) begin
                failures++;
                $display("FAIL random_reads[%0d] ins=%h: n=%0d ad=%0d,%0d expected n=%0d", k, ins, nre, d0, d1, enre);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi_mov2();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
